// File: rtl/pc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_pkg: shared types for the fetch sequencer                      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package pc_pkg;

  typedef enum logic [0:0] {
    PC_RUN    = 1'b0,
    PC_HALTED = 1'b1
  } pc_state_e;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'd0,
    NPC_ABS = 2'd1,
    NPC_REL = 2'd2,
    NPC_RET = 2'd3
  } npc_sel_e;

endpackage
`default_nettype wire

// File: rtl/pc_ret_stack.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_ret_stack: hardware return-address stack (array + pointer)    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pc_ret_stack #(
  parameter int D           = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [D-1:0] push_data,
  output logic [D-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int              c_PW    = $clog2(STACK_DEPTH + 1);
  localparam int              c_IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [c_PW-1:0] c_DEPTH = c_PW'(STACK_DEPTH);
  localparam logic [c_PW-1:0] c_ONE   = c_PW'(1);

  logic [D-1:0]    mem_q [STACK_DEPTH];
  logic [c_PW-1:0] ptr_q, ptr_d;
  logic [c_PW-1:0] w_top_ptr;
  logic            w_push, w_pop;

  assign full      = (ptr_q == c_DEPTH);
  assign empty     = (ptr_q == '0);
  assign w_push    = push & ~full;
  assign w_pop     = pop & ~empty & ~push;
  assign w_top_ptr = ptr_q - c_ONE;
  assign top       = empty ? '0 : mem_q[w_top_ptr[c_IW-1:0]];

  always_comb begin
    ptr_d = ptr_q;
    if (w_push) begin
      ptr_d = ptr_q + c_ONE;
    end else if (w_pop) begin
      ptr_d = ptr_q - c_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Storage needs no reset: entries are only read below the pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[ptr_q[c_IW-1:0]] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pc_sequencer: multi-cycle PC / fetch sequencer with return stack |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int           D           = 12,
  parameter int           CYCLES      = 5,
  parameter int           STACK_DEPTH = 4,
  parameter logic [D-1:0] RESET_VEC   = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      branch_en,
  input  logic                      branch_rel,
  input  logic                      call_en,
  input  logic                      ret_en,
  input  logic                      halt_req,
  input  logic [D-1:0]              target,
  output logic [D-1:0]              prog_ctr,
  output logic [$clog2(CYCLES)-1:0] phase,
  output logic                      instr_done,
  output logic                      halted,
  output logic                      stack_err
);

  localparam int               c_PHW        = $clog2(CYCLES);
  localparam logic [c_PHW-1:0] c_LAST_PHASE = c_PHW'(CYCLES - 1);

  pc_state_e        state_q, state_d;
  logic [c_PHW-1:0] phase_q, phase_d;
  logic [D-1:0]     pc_q, pc_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  npc_sel_e         w_sel;
  logic             w_retire;
  logic             w_push, w_pop, w_err_set;
  logic [D-1:0]     w_seq_pc, w_npc, w_stack_top;
  logic             w_stack_full, w_stack_empty;

  assign w_retire = (state_q == PC_RUN) & ~stall & (phase_q == c_LAST_PHASE);
  assign w_seq_pc = pc_q + D'(1);

  pc_ret_stack #(
    .D           (D),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_seq_pc),
    .top       (w_stack_top),
    .full      (w_stack_full),
    .empty     (w_stack_empty)
  );

  // Priority ret > call > branch; a blocked ret/call falls through to sequential.
  always_comb begin
    w_sel     = NPC_SEQ;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err_set = 1'b0;
    if (w_retire) begin
      if (ret_en) begin
        if (!w_stack_empty) begin
          w_pop = 1'b1;
          w_sel = NPC_RET;
        end else begin
          w_err_set = 1'b1;
        end
      end else if (call_en) begin
        if (!w_stack_full) begin
          w_push = 1'b1;
          w_sel  = branch_rel ? NPC_REL : NPC_ABS;
        end else begin
          w_err_set = 1'b1;
        end
      end else if (branch_en) begin
        w_sel = branch_rel ? NPC_REL : NPC_ABS;
      end
    end
  end

  always_comb begin
    case (w_sel)
      NPC_ABS: w_npc = target;
      NPC_REL: w_npc = pc_q + target;
      NPC_RET: w_npc = w_stack_top;
      default: w_npc = w_seq_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PC_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (w_retire && halt_req) begin
      state_d = PC_HALTED;
    end
  end

  always_comb begin
    halted = (state_q == PC_HALTED);
  end

  always_comb begin
    phase_d = phase_q;
    if (state_q == PC_RUN && !stall) begin
      phase_d = w_retire ? '0 : phase_q + c_PHW'(1);
    end
  end

  assign pc_d = w_retire ? w_npc : pc_q;
  // A halting retirement lands directly in HALTED, where no pulse is allowed.
  assign done_d = w_retire & ~halt_req;
  assign err_d  = err_q | w_err_set;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      pc_q    <= RESET_VEC;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign prog_ctr   = pc_q;
  assign phase      = phase_q;
  assign instr_done = done_q;
  assign stack_err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pc_sequencer: scoreboard bench for pc_sequencer               |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam int           D      = 12;
  localparam int           CYCLES = 5;
  localparam int           DEPTH  = 4;
  localparam logic [D-1:0] RVEC   = 12'h000;

  logic         clk = 1'b0;
  logic         reset, stall, branch_en, branch_rel, call_en, ret_en, halt_req;
  logic [D-1:0] target;
  logic [D-1:0] prog_ctr;
  logic [2:0]   phase;
  logic         instr_done, halted, stack_err;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] exp_q[$];
  logic [D-1:0] m_stack[$];
  logic [D-1:0] m_pc;
  logic         m_err;

  always #5 clk = ~clk;

  pc_sequencer #(
    .D           (D),
    .CYCLES      (CYCLES),
    .STACK_DEPTH (DEPTH),
    .RESET_VEC   (RVEC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_rel (branch_rel),
    .call_en    (call_en),
    .ret_en     (ret_en),
    .halt_req   (halt_req),
    .target     (target),
    .prog_ctr   (prog_ctr),
    .phase      (phase),
    .instr_done (instr_done),
    .halted     (halted),
    .stack_err  (stack_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every instr_done pulse must match the next queued retirement PC.
  always @(negedge clk) begin
    if (instr_done === 1'b1) begin
      check_eq("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_eq("sb_pc", prog_ctr, exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 0; branch_en = 0; branch_rel = 0; call_en = 0; ret_en = 0; halt_req = 0;
    target = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_ctl();
    step();
    m_pc = RVEC;
    m_stack.delete();
    m_err = 0;
    check_eq("rst_pc", prog_ctr, RVEC);
    check_eq("rst_phase", phase, 0);
    check_eq("rst_done", instr_done, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_err", stack_err, 0);
    reset = 0;
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 2 * CYCLES + 4 && phase != 3'(p); i++) step();
    check_eq("wait_phase", phase, p);
  endtask

  task automatic retire(input bit br, input bit rel, input bit call, input bit ret,
                        input bit halt, input logic [D-1:0] tgt);
    logic [D-1:0] npc;
    wait_phase(CYCLES - 1);
    npc = m_pc + 1;
    if (ret) begin
      if (m_stack.size() > 0) npc = m_stack.pop_back();
      else m_err = 1;
    end else if (call) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back(m_pc + 1);
        npc = rel ? m_pc + tgt : tgt;
      end else begin
        m_err = 1;
      end
    end else if (br) begin
      npc = rel ? m_pc + tgt : tgt;
    end
    m_pc = npc;
    if (!halt) exp_q.push_back(npc);
    branch_en = br; branch_rel = rel; call_en = call; ret_en = ret; halt_req = halt;
    target = tgt;
    step();
    clear_ctl();
    check_eq("ret_pc", prog_ctr, m_pc);
    check_eq("ret_phase", phase, 0);
    check_eq("ret_err", stack_err, m_err);
    check_eq("ret_halted", halted, halt);
    check_eq("ret_done", instr_done, !halt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_ctl();
    repeat (2) @(posedge clk);
    do_reset();

    // Boot: phases 1..4 at PC 0, first retirement on the 5th edge.
    for (int i = 1; i < CYCLES; i++) begin
      step();
      check_eq("boot_phase", phase, i);
      check_eq("boot_pc", prog_ctr, RVEC);
      check_eq("boot_done", instr_done, 0);
    end
    retire(0, 0, 0, 0, 0, 12'h000);
    step();
    check_eq("done_one_cycle", instr_done, 0);
    retire(0, 0, 0, 0, 0, 12'h000);

    // Controls outside retirement are ignored.
    wait_phase(1);
    branch_en = 1; call_en = 1; target = 12'h777;
    step();
    clear_ctl();
    check_eq("ignore_pc", prog_ctr, m_pc);

    // Jumps and wrap.
    retire(1, 0, 0, 0, 0, 12'h040);
    retire(1, 0, 0, 0, 0, 12'h005);
    retire(1, 1, 0, 0, 0, 12'hFFE);
    retire(1, 0, 0, 0, 0, 12'hFFF);
    retire(0, 0, 0, 0, 0, 12'h000);

    // Call / return, then return on an empty stack.
    retire(1, 0, 0, 0, 0, 12'h010);
    retire(0, 0, 1, 0, 0, 12'h100);
    retire(0, 0, 0, 1, 0, 12'h000);
    retire(0, 0, 0, 1, 0, 12'h000);

    // Overflow: five nested calls into a four-entry stack.
    do_reset();
    retire(0, 0, 1, 0, 0, 12'h200);
    retire(0, 0, 1, 0, 0, 12'h300);
    retire(0, 1, 1, 0, 0, 12'h100);
    retire(0, 0, 1, 0, 0, 12'h500);
    retire(0, 0, 1, 0, 0, 12'h600);
    retire(0, 0, 0, 0, 0, 12'h000);
    for (int i = 0; i < DEPTH; i++) retire(0, 0, 0, 1, 0, 12'h000);

    // Stall in phase 2, then three stalled cycles on the retirement phase.
    wait_phase(2);
    stall = 1; branch_en = 1; target = 12'h777;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("stall_ph2", phase, 2);
      check_eq("stall_pc2", prog_ctr, m_pc);
    end
    clear_ctl();
    wait_phase(CYCLES - 1);
    stall = 1; branch_en = 1; target = 12'h777;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("stall_ph4", phase, CYCLES - 1);
      check_eq("stall_pc4", prog_ctr, m_pc);
      check_eq("stall_done", instr_done, 0);
    end
    clear_ctl();
    retire(0, 0, 0, 0, 0, 12'h000);

    // ret+call+branch together: pop only.
    do_reset();
    retire(0, 0, 1, 0, 0, 12'h080);
    retire(1, 0, 1, 1, 0, 12'h0F0);
    retire(0, 0, 0, 1, 0, 12'h000);

    // Call from the top of the address space pushes 0.
    retire(1, 0, 0, 0, 0, 12'hFFF);
    retire(0, 0, 1, 0, 0, 12'h050);
    retire(0, 0, 0, 1, 0, 12'h000);

    // Halt with a branch, then everything is ignored.
    retire(1, 0, 0, 0, 1, 12'h020);
    for (int i = 0; i < 20; i++) begin
      stall = 1'($urandom_range(0, 1));
      branch_en = 1'($urandom_range(0, 1));
      branch_rel = 1'($urandom_range(0, 1));
      call_en = 1'($urandom_range(0, 1));
      ret_en = 1'($urandom_range(0, 1));
      halt_req = 1'($urandom_range(0, 1));
      target = D'($urandom);
      step();
      check_eq("halt_pc", prog_ctr, 12'h020);
      check_eq("halt_phase", phase, 0);
      check_eq("halt_flag", halted, 1);
      check_eq("halt_done", instr_done, 0);
    end
    do_reset();

    // Reset in phase 3 abandons the instruction; stack is empty afterwards.
    retire(0, 0, 1, 0, 0, 12'h030);
    wait_phase(3);
    ret_en = 1;
    do_reset();
    retire(0, 0, 0, 1, 0, 12'h000);

    repeat (3) step();
    check_eq("sb_drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
